// File: rtl/pit_timer_array.sv
// pit_timer_array: NUM_CH independent CNT_W-bit down-counting interval timers
// behind one synchronous register port. Each channel has CTRL, RELOAD/COUNT,
// STATUS and LATCH registers. It also has a registered output and a sticky
// interrupt flag.
module pit_timer_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic [NUM_CH-1:0] tick,
    input  logic [NUM_CH-1:0] gate,
    output logic [NUM_CH-1:0] out,
    output logic              irq
);

    localparam logic [1:0]       SEL_CTRL   = 2'd0;
    localparam logic [1:0]       SEL_COUNT  = 2'd1;
    localparam logic [1:0]       SEL_STATUS = 2'd2;
    localparam logic [1:0]       SEL_LATCH  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   N_ONE      = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   N_TWO      = {{(CNT_W-1){1'b0}}, 2'b10};

    logic [1:0]        sel;
    logic [ADDR_W-1:0] ch_addr;

    assign sel     = addr[1:0];
    assign ch_addr = addr >> 2;

    // Per-channel values exported to the shared read mux and irq OR
    logic [NUM_CH-1:0][CNT_W-1:0] count_rd_ch;
    logic [NUM_CH-1:0][3:0]       ctrl_ch;
    logic [NUM_CH-1:0][2:0]       status_ch;
    logic [NUM_CH-1:0]            out_ch;
    logic [NUM_CH-1:0]            pend_d_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] count_q, count_d;
        logic [CNT_W-1:0] reload_q, reload_d;
        logic [CNT_W-1:0] latch_q, latch_d;
        logic [2:0]       mode_q, mode_d;
        logic             irq_en_q, irq_en_d;
        logic             null_q, null_d;
        logic             held_q, held_d;
        logic             trig_q, trig_d;
        logic             out_q, out_d;
        logic             pend_q, pend_d;
        logic             gate_prev_q, gate_prev_d;

        logic             hit, wr_ctrl, wr_reload, wr_status, wr_latch, rd_count;
        logic             gate_rise, tick_eff;
        logic [1:0]       mode_eff;
        logic [CNT_W-1:0] count_dec;
        logic [CNT_W:0]   n_eff;
        logic [CNT_W-1:0] n_hi, n_lo;

        // Counting, gate handling and register side effects for one channel
        always_comb begin
            count_d     = count_q;
            reload_d    = reload_q;
            latch_d     = latch_q;
            mode_d      = mode_q;
            irq_en_d    = irq_en_q;
            null_d      = null_q;
            held_d      = held_q;
            trig_d      = trig_q;
            out_d       = out_q;
            pend_d      = pend_q;
            gate_prev_d = gate[c];

            hit       = (ch_addr == ADDR_W'(c));
            wr_ctrl   = wr_en && hit && (sel == SEL_CTRL);
            wr_reload = wr_en && hit && (sel == SEL_COUNT);
            wr_status = wr_en && hit && (sel == SEL_STATUS);
            wr_latch  = wr_en && hit && (sel == SEL_LATCH);
            rd_count  = rd_en && hit && (sel == SEL_COUNT);

            gate_rise = gate[c] && !gate_prev_q;
            // A CTRL or RELOAD write on the same edge swallows the tick
            tick_eff  = tick[c] && !(wr_ctrl || wr_reload);
            mode_eff  = mode_q[2] ? 2'd0 : mode_q[1:0];
            count_dec = count_q - CNT_ONE;

            // Square-wave half periods; reload 0 is 2^CNT_W, and 1 acts as 2
            n_eff = (reload_q == CNT_ZERO) ? {1'b1, CNT_ZERO} : {1'b0, reload_q};
            if (n_eff == N_ONE) begin
                n_eff = N_TWO;
            end
            n_hi = CNT_W'((n_eff + N_ONE) >> 1);
            n_lo = CNT_W'(n_eff >> 1);

            if ((mode_eff != 2'd0) && gate_rise) begin
                trig_d = 1'b1;
            end
            if (mode_eff[1] && !gate[c]) begin
                out_d = 1'b1;
            end

            if (tick_eff) begin
                unique case (mode_eff)
                    2'd0: begin
                        if (null_q) begin
                            count_d = reload_q;
                            null_d  = 1'b0;
                        end else if (gate[c]) begin
                            count_d = count_dec;
                            if (count_dec == CNT_ZERO) begin
                                out_d = 1'b1;
                            end
                        end
                    end
                    2'd1: begin
                        if (trig_d) begin
                            count_d = reload_q;
                            null_d  = 1'b0;
                            trig_d  = 1'b0;
                            out_d   = 1'b0;
                        end else if (!null_q) begin
                            count_d = count_dec;
                            if (count_dec == CNT_ZERO) begin
                                out_d = 1'b1;
                            end
                        end
                    end
                    2'd2: begin
                        if (gate[c]) begin
                            if (trig_d || null_q) begin
                                count_d = reload_q;
                                null_d  = 1'b0;
                                trig_d  = 1'b0;
                                out_d   = 1'b1;
                            end else if (count_q == CNT_ONE) begin
                                count_d = reload_q;
                                out_d   = 1'b1;
                            end else begin
                                count_d = count_dec;
                                out_d   = (count_dec != CNT_ONE);
                            end
                        end
                    end
                    default: begin
                        if (gate[c]) begin
                            if (trig_d || null_q) begin
                                count_d = n_hi;
                                null_d  = 1'b0;
                                trig_d  = 1'b0;
                                out_d   = 1'b1;
                            end else if (count_q == CNT_ONE) begin
                                if (out_q) begin
                                    count_d = n_lo;
                                    out_d   = 1'b0;
                                end else begin
                                    count_d = n_hi;
                                    out_d   = 1'b1;
                                end
                            end else begin
                                count_d = count_dec;
                            end
                        end
                    end
                endcase
            end

            // Latch is released by a COUNT read; a held latch ignores LATCH writes
            if (rd_count && held_q) begin
                held_d = 1'b0;
            end
            if (wr_latch && !held_q) begin
                latch_d = count_q;
                held_d  = 1'b1;
            end
            if (wr_reload) begin
                reload_d = wr_data;
                null_d   = 1'b1;
            end
            if (wr_ctrl) begin
                mode_d   = wr_data[2:0];
                irq_en_d = wr_data[3];
                null_d   = 1'b1;
                held_d   = 1'b0;
                trig_d   = 1'b0;
                out_d    = !(wr_data[2] || (wr_data[1:0] == 2'd0));
            end

            // Set beats clear when both land on the same edge
            if (wr_status && wr_data[0]) begin
                pend_d = 1'b0;
            end
            if (out_d && !out_q && irq_en_q) begin
                pend_d = 1'b1;
            end
        end

        // Channel state registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q     <= '0;
                reload_q    <= '0;
                latch_q     <= '0;
                mode_q      <= 3'd0;
                irq_en_q    <= 1'b0;
                null_q      <= 1'b1;
                held_q      <= 1'b0;
                trig_q      <= 1'b0;
                out_q       <= 1'b0;
                pend_q      <= 1'b0;
                gate_prev_q <= 1'b0;
            end else begin
                count_q     <= count_d;
                reload_q    <= reload_d;
                latch_q     <= latch_d;
                mode_q      <= mode_d;
                irq_en_q    <= irq_en_d;
                null_q      <= null_d;
                held_q      <= held_d;
                trig_q      <= trig_d;
                out_q       <= out_d;
                pend_q      <= pend_d;
                gate_prev_q <= gate_prev_d;
            end
        end

        assign count_rd_ch[c] = held_q ? latch_q : count_q;
        assign ctrl_ch[c]     = {irq_en_q, mode_q};
        assign status_ch[c]   = {out_q, null_q, pend_q};
        assign out_ch[c]      = out_q;
        assign pend_d_ch[c]   = pend_d;
    end

    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             irq_q, irq_d;

    // Read mux works on pre-edge state, so same-cycle writes/ticks are not visible
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = rd_en;
        irq_d      = |pend_d_ch;
        if (rd_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_addr == ADDR_W'(i)) begin
                    unique case (sel)
                        SEL_CTRL:   rd_data_d = CNT_W'(ctrl_ch[i]);
                        SEL_COUNT:  rd_data_d = count_rd_ch[i];
                        SEL_STATUS: rd_data_d = CNT_W'(status_ch[i]);
                        default:    rd_data_d = '0;
                    endcase
                end
            end
        end
    end

    // Read port and interrupt output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;
    assign out      = out_ch;

endmodule
